// File: rtl/zeroriscy_vrf_wb_sequencer.sv
// Vector register file write-back sequencer.
// Arbitrates the ALU and LSU (round-robin) for the single lane-wide write
// port, latches one whole-vector write and issues it one lane per cycle.
// It also flags read-after-write hazards against the in-flight destination.
// Optional feature macro: ZERORISCY_VRF_WB_SKIP_MASKED_EN. When it is defined,
// lanes whose mask bit is 0 take no beat.
module zeroriscy_vrf_wb_sequencer #(
  parameter int NUM_LANES  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            alu_req_i,
  output logic                            alu_gnt_o,
  input  logic [ADDR_WIDTH-1:0]           alu_waddr_i,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] alu_wdata_i,
  input  logic [NUM_LANES-1:0]            alu_mask_i,
  input  logic                            lsu_req_i,
  output logic                            lsu_gnt_o,
  input  logic [ADDR_WIDTH-1:0]           lsu_waddr_i,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] lsu_wdata_i,
  input  logic [NUM_LANES-1:0]            lsu_mask_i,
  output logic                            vrf_we_o,
  output logic [ADDR_WIDTH-1:0]           vrf_waddr_o,
  output logic [$clog2(NUM_LANES)-1:0]    vrf_wlane_o,
  output logic [DATA_WIDTH-1:0]           vrf_wdata_o,
  input  logic [ADDR_WIDTH-1:0]           rd_addr_a_i,
  input  logic [ADDR_WIDTH-1:0]           rd_addr_b_i,
  output logic                            hazard_a_o,
  output logic                            hazard_b_o,
  output logic                            busy_o,
  output logic                            done_o,
  output logic                            done_src_o
);

  localparam int LANE_W = $clog2(NUM_LANES);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_e;

  state_e                          state_r, state_nxt_s;
  logic [LANE_W-1:0]               lane_r, lane_nxt_s;
  logic [ADDR_WIDTH-1:0]           addr_r, addr_nxt_s;
  logic [NUM_LANES*DATA_WIDTH-1:0] data_r, data_nxt_s;
  logic [NUM_LANES-1:0]            mask_r, mask_nxt_s;
  logic                            src_r, src_nxt_s;
  logic                            last_lsu_r, last_lsu_nxt_s;

  logic                            alu_gnt_s, lsu_gnt_s;
  logic                            accept_s, final_s, grant_ok_s;
  logic [ADDR_WIDTH-1:0]           new_addr_s;
  logic [NUM_LANES*DATA_WIDTH-1:0] new_data_s;
  logic [NUM_LANES-1:0]            new_mask_s;

`ifdef ZERORISCY_VRF_WB_SKIP_MASKED_EN
  logic [LANE_W:0]                 first_lane_s, next_lane_s;

  // Lowest set mask bit at index >= from; the MSB of the result flags "found".
  function automatic logic [LANE_W:0] find_lane(input logic [NUM_LANES-1:0] m, input int from);
    logic [LANE_W:0] r;
    r = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (m[i] && (i >= from)) begin
        r = {1'b1, LANE_W'(i)};
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  assign first_lane_s = find_lane(new_mask_s, 0);
  assign next_lane_s  = find_lane(mask_r, int'(lane_r) + 1);
`endif

  // Final-beat detection: the write ends on its last lane to be issued.
  always_comb begin
    final_s = 1'b0;
    if (state_r == ST_WRITE) begin
`ifdef ZERORISCY_VRF_WB_SKIP_MASKED_EN
      final_s = ~next_lane_s[LANE_W];
`else
      final_s = (lane_r == LANE_W'(NUM_LANES - 1));
`endif
    end else begin
      final_s = 1'b0;
    end
  end

  assign grant_ok_s = (state_r == ST_IDLE) | final_s;

  // Round-robin arbitration; a tie goes to the requester not granted last.
  always_comb begin
    alu_gnt_s = 1'b0;
    lsu_gnt_s = 1'b0;
    if (grant_ok_s) begin
      if (alu_req_i && lsu_req_i) begin
        alu_gnt_s = last_lsu_r;
        lsu_gnt_s = ~last_lsu_r;
      end else begin
        alu_gnt_s = alu_req_i;
        lsu_gnt_s = lsu_req_i;
      end
    end else begin
      alu_gnt_s = 1'b0;
      lsu_gnt_s = 1'b0;
    end
  end

  assign accept_s   = alu_gnt_s | lsu_gnt_s;
  assign new_addr_s = lsu_gnt_s ? lsu_waddr_i : alu_waddr_i;
  assign new_data_s = lsu_gnt_s ? lsu_wdata_i : alu_wdata_i;
  assign new_mask_s = lsu_gnt_s ? lsu_mask_i  : alu_mask_i;
  assign alu_gnt_o  = alu_gnt_s;
  assign lsu_gnt_o  = lsu_gnt_s;

  // Next-state: an accept (re)loads the write, else advance or finish.
  always_comb begin
    state_nxt_s    = state_r;
    lane_nxt_s     = lane_r;
    addr_nxt_s     = addr_r;
    data_nxt_s     = data_r;
    mask_nxt_s     = mask_r;
    src_nxt_s      = src_r;
    last_lsu_nxt_s = last_lsu_r;
    if (accept_s) begin
      state_nxt_s    = ST_WRITE;
      addr_nxt_s     = new_addr_s;
      data_nxt_s     = new_data_s;
      mask_nxt_s     = new_mask_s;
      src_nxt_s      = lsu_gnt_s;
      last_lsu_nxt_s = lsu_gnt_s;
`ifdef ZERORISCY_VRF_WB_SKIP_MASKED_EN
      lane_nxt_s     = first_lane_s[LANE_W-1:0];
`else
      lane_nxt_s     = '0;
`endif
    end else if (final_s) begin
      state_nxt_s = ST_IDLE;
      lane_nxt_s  = '0;
    end else if (state_r == ST_WRITE) begin
`ifdef ZERORISCY_VRF_WB_SKIP_MASKED_EN
      lane_nxt_s = next_lane_s[LANE_W-1:0];
`else
      lane_nxt_s = lane_r + LANE_W'(1);
`endif
    end else begin
      lane_nxt_s = lane_r;
    end
  end

  // State and operand registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      lane_r     <= '0;
      addr_r     <= '0;
      data_r     <= '0;
      mask_r     <= '0;
      src_r      <= 1'b0;
      last_lsu_r <= 1'b1;
    end else begin
      state_r    <= state_nxt_s;
      lane_r     <= lane_nxt_s;
      addr_r     <= addr_nxt_s;
      data_r     <= data_nxt_s;
      mask_r     <= mask_nxt_s;
      src_r      <= src_nxt_s;
      last_lsu_r <= last_lsu_nxt_s;
    end
  end

  // Write-port and status outputs, driven from registers and forced to 0 in IDLE.
  always_comb begin
    vrf_we_o    = 1'b0;
    vrf_waddr_o = '0;
    vrf_wlane_o = '0;
    vrf_wdata_o = '0;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    done_src_o  = 1'b0;
    if (state_r == ST_WRITE) begin
      vrf_we_o    = mask_r[lane_r];
      vrf_waddr_o = addr_r;
      vrf_wlane_o = lane_r;
      vrf_wdata_o = data_r[int'(lane_r)*DATA_WIDTH +: DATA_WIDTH];
      busy_o      = 1'b1;
      done_o      = final_s;
      done_src_o  = final_s & src_r;
    end else begin
      busy_o = 1'b0;
    end
  end

  assign hazard_a_o = busy_o & (rd_addr_a_i == addr_r);
  assign hazard_b_o = busy_o & (rd_addr_b_i == addr_r);

endmodule

// File: doc/zeroriscy_vrf_wb_sequencer.md
# zeroriscy_vrf_wb_sequencer

Write-back sequencer and arbiter for the vector register file. It shares the file's single 32-bit write port between the vector ALU and the vector load/store unit. It accepts one whole-vector write (NUM_LANES × 32 bit) at a time and serialises it into one lane write per cycle. While a write is in flight, it flags read-after-write hazards to issue logic.

## Interface
Parameters:
- NUM_LANES, 4, elements per vector register; power of two, ≥2
- DATA_WIDTH, 32, element width
- ADDR_WIDTH, 4, vector register index width (16 registers)

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - clk  in  1  clock
  - rst  in  1  reset
- ALU requester:
  - alu_req_i  in  1  ALU write request
  - alu_gnt_o  out  1  ALU request accepted this cycle
  - alu_waddr_i  in  ADDR_WIDTH  destination register
  - alu_wdata_i  in  NUM_LANES*DATA_WIDTH  vector data; lane i = bits [i*DATA_WIDTH +: DATA_WIDTH]
  - alu_mask_i  in  NUM_LANES  lane write enables
- LSU requester (same meanings as the ALU ports):
  - lsu_req_i  in  1
  - lsu_gnt_o  out  1
  - lsu_waddr_i  in  ADDR_WIDTH
  - lsu_wdata_i  in  NUM_LANES*DATA_WIDTH
  - lsu_mask_i  in  NUM_LANES
- Register file write port:
  - vrf_we_o  out  1  lane write strobe
  - vrf_waddr_o  out  ADDR_WIDTH  register index
  - vrf_wlane_o  out  log2(NUM_LANES)  lane index
  - vrf_wdata_o  out  DATA_WIDTH  lane data
- Hazard detection:
  - rd_addr_a_i, rd_addr_b_i  in  ADDR_WIDTH  issue-stage source registers
  - hazard_a_o, hazard_b_o  out  1  source matches the in-flight destination
- Status:
  - busy_o  out  1  sequencer in WRITE
  - done_o  out  1  one-cycle pulse on the final beat
  - done_src_o  out  1  source of the completing write; 0 = ALU, 1 = LSU

## Operation
- FSM states:
  - IDLE: no write in flight.
  - WRITE: beats are being issued.
- Accept:
  - An accept occurs on any cycle with req & gnt.
  - Address, data, mask and source are latched, lane counter is set to the first beat, and the FSM moves to WRITE.
- Grant:
  - Grants are combinational from req.
  - A grant is given only in IDLE, or in WRITE on the final beat.
  - At most one gnt is high per cycle.
- Arbitration is round-robin:
  - If both requesters are high, grant the one not granted last.
  - A single requester is always granted when a grant is allowed.
  - After reset the last-granted pointer = LSU, so the ALU wins the first tie.
- Requester obligations: hold req and operands stable until gnt.
- Beats: one lane per cycle, in ascending lane order.
  - vrf_wlane_o = lane counter.
  - vrf_wdata_o = latched lane slice.
  - vrf_waddr_o = latched address.
  - vrf_we_o = mask[lane].
- Completion:
  - On the final beat, done_o = 1.
  - If no new accept occurs that cycle, the FSM returns to IDLE.
  - If an accept occurs that cycle, the FSM stays in WRITE with the new operands.
- Hazards: hazard_x_o = busy_o & (rd_addr_x_i == latched waddr). Combinational. Set even if the mask is partial.
- In IDLE, all write-port outputs are 0.

## Timing
- Reset takes effect on the rising edge with rst = 1:
  - FSM to IDLE, lane counter 0, last-granted pointer = LSU.
  - All outputs 0 (gnt still follows req combinationally in IDLE after reset).
- Reset mid-WRITE aborts the write: remaining beats are dropped and no done_o is produced.
- Latency:
  - Accept at edge T (req & gnt sampled high).
  - Lane 0 beat in cycle T+1; final beat, with done_o, in cycle T+NUM_LANES (full-length mode).
- Back-to-back:
  - A grant on the final beat puts the next write's lane 0 in the immediately following cycle.
  - Port throughput is 100%.
- Simultaneous requests during WRITE (not on the final beat): no grant. Both requesters wait.

## Configuration
- Macro: ZERORISCY_VRF_WB_SKIP_MASKED_EN.
- Undefined:
  - Every write takes exactly NUM_LANES beats.
  - Masked lanes take a beat with vrf_we_o = 0.
- Defined:
  - Only lanes with mask = 1 take beats, in ascending order.
  - The final beat is the highest set lane.
  - An all-zero mask takes one cycle: vrf_we_o = 0, done_o = 1, in cycle T+1.
  - Latency to done = popcount(mask) cycles (minimum 1).

## Test plan
- ALU req, waddr = 5, mask = 1111, data lanes = 0x11/0x22/0x33/0x44 → gnt in same cycle; we = 1 on cycles T+1..T+4 with lanes 0..3 and those data; done_o and done_src_o = 0 at T+4.
- ALU and LSU both request after reset → ALU granted first; LSU granted on the ALU final beat; LSU lane 0 at T+5; done_src_o = 1 at T+8.
- LSU mask = 0101, waddr = 9 → undefined macro: 4 beats, we = 1 only on lanes 0 and 2; defined macro: 2 beats (lanes 0, 2), done at T+2.
- Mask = 0000 with macro defined → no we, done_o at T+1, FSM in IDLE at T+2.
- ALU write to waddr = 3 in flight, rd_addr_a_i = 3, rd_addr_b_i = 4 → hazard_a_o = 1, hazard_b_o = 0 until done; both 0 afterwards.
- rst asserted at T+2 of a 4-beat write → no further we, no done_o; outputs 0 next cycle; the next tie is won by the ALU.
